// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer: decoder states,
// prefix and ignored byte values, the queued event record and a BCD helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // Keyboard status/response bytes that never encode a key
  localparam logic [7:0] IGN_ERR0   = 8'h00;
  localparam logic [7:0] IGN_BAT_OK = 8'hAA;
  localparam logic [7:0] IGN_ECHO   = 8'hEE;
  localparam logic [7:0] IGN_ACK    = 8'hFA;
  localparam logic [7:0] IGN_RESEND = 8'hFE;
  localparam logic [7:0] IGN_ERR1   = 8'hFF;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
  } ps2_event_t;

  localparam int EVENT_W = $bits(ps2_event_t);

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_ERR0) || (b == IGN_BAT_OK) || (b == IGN_ECHO) ||
           (b == IGN_ACK)  || (b == IGN_RESEND) || (b == IGN_ERR1);
  endfunction

  // Two-digit BCD increment, 99 wraps to 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event queue. Head is visible combinationally so a
// push in cycle N shows up as out_valid in cycle N+1; data reads as zero when empty.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             pop;
  logic             wr_en;

  always_comb begin
    full      = (count_q == FULL_CNT);
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    pop       = out_valid && pop_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts
    wr_en     = push && (!full || pop);
    drop      = push && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Decodes PS/2 set-2 scan bytes into make/break key events, filters typematic
// repeats of the held key, counts presses in BCD and queues events for a consumer.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_make,
  output logic       held,
  output logic [7:0] press_cnt,
  output logic       overflow
);

  ps2_state_e       state_q, state_d;
  logic             held_valid_q, held_valid_d;
  logic [8:0]       held_key_q, held_key_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             overflow_q, overflow_d;

  logic             dec_fire;
  logic             dec_make;
  logic             dec_ext;
  logic [8:0]       dec_key;
  logic             same_key;
  logic             push;
  ps2_event_t       push_ev;
  ps2_event_t       head_ev;
  logic [EVENT_W-1:0] head_bits;
  logic             fifo_drop;

  always_comb begin
    state_d  = state_q;
    dec_fire = 1'b0;
    dec_make = 1'b0;
    dec_ext  = 1'b0;
    if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_data == PREFIX_EXT)      state_d = ST_EXT;
          else if (byte_data == PREFIX_BRK) state_d = ST_BRK;
          else if (!is_ignored(byte_data)) begin
            dec_fire = 1'b1;
            dec_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (byte_data == PREFIX_BRK)      state_d = ST_EXT_BRK;
          else if (byte_data != PREFIX_EXT) begin
            dec_fire = 1'b1;
            dec_make = 1'b1;
            dec_ext  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (byte_data != PREFIX_EXT && byte_data != PREFIX_BRK) begin
            dec_fire = 1'b1;
            dec_ext  = (state_q == ST_EXT_BRK);
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_key      = {dec_ext, byte_data};
    same_key     = held_valid_q && (held_key_q == dec_key);
    push         = 1'b0;
    held_valid_d = held_valid_q;
    held_key_d   = held_key_q;
    press_cnt_d  = press_cnt_q;
    if (dec_fire) begin
      if (dec_make) begin
        // A make of the key already held is typematic repeat
        if (!same_key) begin
          push         = 1'b1;
          held_key_d   = dec_key;
          held_valid_d = 1'b1;
          press_cnt_d  = bcd_inc(press_cnt_q);
        end
      end else begin
        push = 1'b1;
        if (same_key) held_valid_d = 1'b0;
      end
    end
    push_ev.code = byte_data;
    push_ev.ext  = dec_ext;
    push_ev.make = dec_make;
    overflow_d   = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      held_valid_q <= 1'b0;
      held_key_q   <= '0;
      press_cnt_q  <= 8'h00;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_valid_q <= held_valid_d;
      held_key_q   <= held_key_d;
      press_cnt_q  <= press_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_ev),
    .pop_ready (ev_ready),
    .out_valid (ev_valid),
    .out_data  (head_bits),
    .drop      (fifo_drop)
  );

  assign head_ev   = head_bits;
  assign ev_code   = head_ev.code;
  assign ev_ext    = head_ev.ext;
  assign ev_make   = head_ev.make;
  assign held      = held_valid_q;
  assign press_cnt = press_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench: directed scenarios plus random byte streams, compared
// every cycle against a prefix-flag / queue reference model of the key sequencer.
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_make;
  logic       held;
  logic [7:0] press_cnt;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_make    (ev_make),
    .held       (held),
    .press_cnt  (press_cnt),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending-prefix flags, event list, held key, press total
  bit         m_ext_pfx;
  bit         m_brk_pfx;
  logic [9:0] mq[$];
  bit         m_held;
  logic [8:0] m_held_key;
  int         m_presses;
  bit         m_ovf;
  logic [9:0] dut_pops[$];

  function automatic logic [7:0] to_bcd(input int n);
    int m;
    m = n % 100;
    return 8'(((m / 10) << 4) | (m % 10));
  endfunction

  function automatic bit ignored_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext_pfx  = 0;
    m_brk_pfx  = 0;
    mq.delete();
    m_held     = 0;
    m_held_key = '0;
    m_presses  = 0;
    m_ovf      = 0;
  endtask

  task automatic check_all();
    logic [9:0] head;
    head = (mq.size() != 0) ? mq[0] : 10'd0;
    chk("ev_valid",  ev_valid,  (mq.size() != 0));
    chk("ev_code",   ev_code,   head[9:2]);
    chk("ev_ext",    ev_ext,    head[1]);
    chk("ev_make",   ev_make,   head[0]);
    chk("held",      held,      m_held);
    chk("press_cnt", press_cnt, to_bcd(m_presses));
    chk("overflow",  overflow,  m_ovf);
  endtask

  task automatic model_step(input bit bv, input logic [7:0] b, input bit rdy);
    bit         fire;
    bit         mk;
    bit         ex;
    bit         emit;
    logic [8:0] key;
    fire = 0; mk = 0; ex = 0; emit = 0;
    if (bv) begin
      if (m_brk_pfx) begin
        if (b != 8'hE0 && b != 8'hF0) begin
          fire = 1; mk = 0; ex = m_ext_pfx;
          m_ext_pfx = 0; m_brk_pfx = 0;
        end
      end else if (m_ext_pfx) begin
        if (b == 8'hF0) m_brk_pfx = 1;
        else if (b != 8'hE0) begin
          fire = 1; mk = 1; ex = 1;
          m_ext_pfx = 0;
        end
      end else begin
        if (b == 8'hE0) m_ext_pfx = 1;
        else if (b == 8'hF0) m_brk_pfx = 1;
        else if (!ignored_byte(b)) begin
          fire = 1; mk = 1; ex = 0;
        end
      end
    end
    key = {ex, b};
    if (fire) begin
      if (mk) begin
        if (!(m_held && m_held_key == key)) begin
          emit = 1;
          m_held = 1;
          m_held_key = key;
          m_presses++;
        end
      end else begin
        emit = 1;
        if (m_held && m_held_key == key) m_held = 0;
      end
    end
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() < DEPTH) mq.push_back({b, ex, mk});
      else m_ovf = 1;
    end
  endtask

  task automatic step(input bit bv, input logic [7:0] b, input bit rdy);
    check_all();
    if (ev_valid && rdy) begin
      dut_pops.push_back({ev_code, ev_ext, ev_make});
      $display("pop code=%02h ext=%0d make=%0d t=%0t", ev_code, ev_ext, ev_make, $time);
    end
    byte_valid = bv;
    byte_data  = b;
    ev_ready   = rdy;
    model_step(bv, b, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    check_all();
    resetn     = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hF0;
    ev_ready   = 1'b1;
    model_reset();
    @(negedge clk);
    resetn     = 1'b1;
    byte_valid = 1'b0;
    dut_pops.delete();
  endtask

  initial begin
    logic [7:0] keys6[6];
    logic [7:0] codes[8];
    logic [7:0] ign[6];
    keys6 = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    codes = '{8'h1C, 8'h1D, 8'h75, 8'h6B, 8'h5A, 8'h29, 8'h1B, 8'h74};
    ign   = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_valid", ev_valid, 1'b0);
    chk("rst_cnt",   press_cnt, 8'h00);
    chk("rst_held",  held, 1'b0);
    chk("rst_ovf",   overflow, 1'b0);
    resetn = 1'b1;
    dut_pops.delete();

    // Plain make/break
    step(1, 8'h1C, 1);
    chk("s1_held_on", held, 1'b1);
    step(1, 8'hF0, 1);
    step(1, 8'h1C, 1);
    chk("s1_held_off", held, 1'b0);
    repeat (3) step(0, 8'h00, 1);
    chk("s1_npops", dut_pops.size(), 2);
    chk("s1_ev0", dut_pops[0], {8'h1C, 1'b0, 1'b1});
    chk("s1_ev1", dut_pops[1], {8'h1C, 1'b0, 1'b0});
    chk("s1_cnt", press_cnt, 8'h01);

    // Extended make/break
    do_reset();
    step(1, 8'hE0, 1); step(1, 8'h75, 1);
    step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h75, 1);
    repeat (3) step(0, 8'h00, 1);
    chk("s2_npops", dut_pops.size(), 2);
    chk("s2_ev0", dut_pops[0], {8'h75, 1'b1, 1'b1});
    chk("s2_ev1", dut_pops[1], {8'h75, 1'b1, 1'b0});

    // Typematic repeats suppressed
    do_reset();
    step(1, 8'h1C, 1); step(1, 8'h1C, 1); step(1, 8'h1C, 1);
    step(1, 8'hF0, 1); step(1, 8'h1C, 1);
    repeat (3) step(0, 8'h00, 1);
    chk("s3_npops", dut_pops.size(), 2);
    chk("s3_cnt", press_cnt, 8'h01);

    // Overflow with stalled consumer, then drain
    do_reset();
    for (int i = 0; i < 6; i++) step(1, keys6[i], 0);
    chk("s4_ovf", overflow, 1'b1);
    chk("s4_cnt", press_cnt, 8'h06);
    step(0, 8'h00, 0);
    repeat (6) step(0, 8'h00, 1);
    chk("s4_npops", dut_pops.size(), 4);
    for (int i = 0; i < 4; i++) chk("s4_order", dut_pops[i], {keys6[i], 1'b0, 1'b1});
    chk("s4_empty", ev_valid, 1'b0);

    // BCD wrap 99 -> 00
    do_reset();
    for (int i = 1; i <= 99; i++) begin
      step(1, 8'(i), 1); step(1, 8'hF0, 1); step(1, 8'(i), 1);
    end
    repeat (3) step(0, 8'h00, 1);
    chk("s5_cnt99", press_cnt, 8'h99);
    step(1, 8'h70, 1);
    step(0, 8'h00, 1);
    chk("s5_cnt00", press_cnt, 8'h00);

    // Reset discards pending prefix
    do_reset();
    step(1, 8'hE0, 1); step(1, 8'hF0, 1);
    do_reset();
    step(1, 8'h1C, 1);
    repeat (3) step(0, 8'h00, 1);
    chk("s6_npops", dut_pops.size(), 1);
    chk("s6_ev0", dut_pops[0], {8'h1C, 1'b0, 1'b1});

    // Random byte streams with varying consumer backpressure
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int         r;
      logic [7:0] b;
      bit         bv;
      bit         rdy;
      r = $urandom_range(0, 15);
      if (r < 3)       b = 8'hE0;
      else if (r < 6)  b = 8'hF0;
      else if (r < 7)  b = ign[$urandom_range(0, 5)];
      else             b = codes[$urandom_range(0, 7)];
      bv  = ($urandom_range(0, 3) != 0);
      rdy = (i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(bv, b, rdy);
    end
    step(0, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, event queue entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: byte_valid  input  1  one-cycle strobe, byte_data holds a received scan byte.
REQ-005 SHALL have port: byte_data  input  8  scan byte from the PS/2 receiver.
REQ-006 SHALL have port: ev_valid  output  1  queue head holds a key event.
REQ-007 SHALL have port: ev_ready  input  1  consumer accepts the head event.
REQ-008 SHALL have port: ev_code  output  8  scan code of the head event.
REQ-009 SHALL have port: ev_ext  output  1  head event was E0-prefixed.
REQ-010 SHALL have port: ev_make  output  1  1 = press, 0 = release.
REQ-011 SHALL have port: held  output  1  a key is currently held.
REQ-012 SHALL have port: press_cnt  output  8  BCD press count: [7:4] tens, [3:0] units.
REQ-013 SHALL have port: overflow  output  1  sticky: an event was dropped on a full queue.

Function
REQ-014 SHALL decode with FSM states IDLE, EXT, BRK, EXT_BRK; the FSM advances only on byte_valid.
REQ-015 IDLE: E0 -> EXT; F0 -> BRK; 00, AA, EE, FA, FE, FF -> ignored, stay IDLE; any other byte -> make event {ext=0}, stay IDLE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> make event {ext=1}, go IDLE.
REQ-017 BRK and EXT_BRK: E0 or F0 -> ignored, state unchanged; any other byte -> break event (ext=0 from BRK, ext=1 from EXT_BRK), go IDLE.
REQ-018 SHALL keep one held-key register {ext, code} plus a valid bit driving held.
REQ-019 Make of the key in the held register SHALL be suppressed as typematic repeat: no event, no count.
REQ-020 Make of a different key SHALL emit the event, overwrite the held register and set held.
REQ-021 Break of the held key SHALL emit the event and clear held; break of any other key SHALL emit the event and leave held unchanged.
REQ-022 press_cnt SHALL increment by one BCD step on every non-suppressed make, whether or not the queue accepts it; units 9 -> 0 carries to tens; 99 -> 00 wraps.
REQ-023 Events SHALL go through a first-word-fall-through queue of FIFO_DEPTH entries; with the queue empty, a byte strobed in cycle N SHALL give ev_valid=1 in cycle N+1.
REQ-024 Pop SHALL occur when ev_valid and ev_ready are both high in the same cycle; ev_code, ev_ext and ev_make SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-025 Push with the queue full and no pop in the same cycle SHALL drop the new event and set overflow, which stays set until reset.
REQ-026 Push and pop in the same cycle with the queue full SHALL both succeed: occupancy unchanged, no overflow.
REQ-027 When ev_valid=0, ev_code, ev_ext and ev_make SHALL be 0.

Reset
REQ-028 With resetn=0 at a clk edge: FSM to IDLE, queue empty, ev_valid=0, held=0, held register cleared, press_cnt=8'h00, overflow=0.
REQ-029 Reset mid-sequence (after E0 or F0) SHALL discard the pending prefix; the next byte is decoded from IDLE.
REQ-030 byte_valid SHALL be ignored in any cycle where resetn=0.

Structure
REQ-031 Shared package ps2_pkg SHALL hold: FSM state enum, constants PREFIX_EXT=8'hE0 and PREFIX_BRK=8'hF0, the ignored-byte constants, and the event record {code[7:0], ext, make} (10 bits).
REQ-032 The queue SHALL be a sub-module named ps2_event_fifo, parameterised by FIFO_DEPTH and the event width.

Verification
REQ-033 Bytes 1C, F0, 1C with ev_ready=1 -> events {1C,ext0,make1} then {1C,ext0,make0}; press_cnt=01; held=1 then 0.
REQ-034 Bytes E0, 75, E0, F0, 75 -> events {75,ext1,make1}, {75,ext1,make0}; no event for either prefix byte.
REQ-035 Bytes 1C, 1C, 1C, F0, 1C -> exactly 2 events (one make, one break); press_cnt=01.
REQ-036 ev_ready=0, makes of 6 distinct keys (FIFO_DEPTH=4) -> 4 queued in order, overflow=1, press_cnt=06; then ev_ready=1 -> the first 4 events drain, then ev_valid=0.
REQ-037 Preload press_cnt to 99 via 99 distinct make/break pairs, then one more make -> press_cnt=00.
REQ-038 Bytes E0, F0, then resetn=0 for one cycle, then 1C -> single event {1C,ext0,make1}.
